// File: rtl/axi_arb_pkg.sv
// Shared types and field widths for the two-master AXI write-path arbiter.
package axi_arb_pkg;

    localparam int ID_W    = 9;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    localparam logic [RESP_W-1:0] OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// AXI write-path bundle (AW, W, B). "master" drives AW/W and consumes B;
// "slave" is the mirror image.
interface axi_wr_arbiter_if #(
    parameter int A_WIDTH = 16,
    parameter int D_WIDTH = 16
);
    logic [axi_arb_pkg::ID_W-1:0]    awid;
    logic [A_WIDTH-1:0]              awaddr;
    logic [axi_arb_pkg::LEN_W-1:0]   awlen;
    logic [axi_arb_pkg::SIZE_W-1:0]  awsize;
    logic [axi_arb_pkg::BURST_W-1:0] awburst;
    logic                            awvalid;
    logic                            awready;

    logic [axi_arb_pkg::ID_W-1:0]    wid;
    logic [D_WIDTH-1:0]              wdata;
    logic [D_WIDTH/8-1:0]            wstrb;
    logic                            wlast;
    logic                            wvalid;
    logic                            wready;

    logic [axi_arb_pkg::ID_W-1:0]    bid;
    logic [axi_arb_pkg::RESP_W-1:0]  bresp;
    logic                            bvalid;
    logic                            bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_rr_arb2.sv
// Two-requester round-robin picker. A lone requester wins outright; on a tie
// the requester that was not served last wins.
module axi_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    // Combinational pick; with no request the output is a don't-care.
    always_comb begin
        gnt = ~last;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            default: gnt = ~last;
        endcase
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master to one-slave AXI write arbiter. One burst in flight at a time,
// grant held from AW acceptance through the B handshake, round-robin between
// masters, with a sticky flag for beat-count and ID protocol violations.
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int A_WIDTH = 16,
    parameter int D_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    axi_wr_arbiter_if.slave  m0,
    axi_wr_arbiter_if.slave  m1,
    axi_wr_arbiter_if.master s,
    output logic             grant,
    output logic             busy,
    output logic             prot_err
);

    arb_state_e        state_reg, state_next;
    logic              grant_reg, grant_next;
    logic              rr_last_reg, rr_last_next;
    logic [LEN_W-1:0]  beat_cnt_reg, beat_cnt_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [ID_W-1:0]   id_reg, id_next;
    logic              prot_err_reg, prot_err_next;

    logic              pick_gnt;

    logic [ID_W-1:0]      sel_awid;
    logic [A_WIDTH-1:0]   sel_awaddr;
    logic [LEN_W-1:0]     sel_awlen;
    logic [SIZE_W-1:0]    sel_awsize;
    logic [BURST_W-1:0]   sel_awburst;
    logic                 sel_awvalid;
    logic [ID_W-1:0]      sel_wid;
    logic [D_WIDTH-1:0]   sel_wdata;
    logic [D_WIDTH/8-1:0] sel_wstrb;
    logic                 sel_wlast;
    logic                 sel_wvalid;
    logic                 sel_bready;

    logic in_addr, in_data, in_resp;
    logic aw_hs, w_hs, b_hs;

    axi_rr_arb2 u_pick (
        .req  ({m1.awvalid, m0.awvalid}),
        .last (rr_last_reg),
        .gnt  (pick_gnt)
    );

    // Route the owning master's request-side signals onto one set of wires.
    always_comb begin
        sel_awid    = grant_reg ? m1.awid    : m0.awid;
        sel_awaddr  = grant_reg ? m1.awaddr  : m0.awaddr;
        sel_awlen   = grant_reg ? m1.awlen   : m0.awlen;
        sel_awsize  = grant_reg ? m1.awsize  : m0.awsize;
        sel_awburst = grant_reg ? m1.awburst : m0.awburst;
        sel_awvalid = grant_reg ? m1.awvalid : m0.awvalid;
        sel_wid     = grant_reg ? m1.wid     : m0.wid;
        sel_wdata   = grant_reg ? m1.wdata   : m0.wdata;
        sel_wstrb   = grant_reg ? m1.wstrb   : m0.wstrb;
        sel_wlast   = grant_reg ? m1.wlast   : m0.wlast;
        sel_wvalid  = grant_reg ? m1.wvalid  : m0.wvalid;
        sel_bready  = grant_reg ? m1.bready  : m0.bready;
    end

    assign in_addr = (state_reg == ADDR);
    assign in_data = (state_reg == DATA);
    assign in_resp = (state_reg == RESP);

    assign aw_hs = in_addr && sel_awvalid && s.awready;
    assign w_hs  = in_data && sel_wvalid  && s.wready;
    assign b_hs  = in_resp && s.bvalid    && sel_bready;

    // Slave side: payload always follows the owner, valids only in their phase.
    assign s.awid    = sel_awid;
    assign s.awaddr  = sel_awaddr;
    assign s.awlen   = sel_awlen;
    assign s.awsize  = sel_awsize;
    assign s.awburst = sel_awburst;
    assign s.awvalid = in_addr && sel_awvalid;
    assign s.wid     = sel_wid;
    assign s.wdata   = sel_wdata;
    assign s.wstrb   = sel_wstrb;
    assign s.wlast   = sel_wlast;
    assign s.wvalid  = in_data && sel_wvalid;
    assign s.bready  = in_resp && sel_bready;

    // Master side: only the owner ever sees a ready or a response valid, so
    // early W data from the other master simply stalls.
    assign m0.awready = in_addr && !grant_reg && s.awready;
    assign m1.awready = in_addr &&  grant_reg && s.awready;
    assign m0.wready  = in_data && !grant_reg && s.wready;
    assign m1.wready  = in_data &&  grant_reg && s.wready;
    assign m0.bvalid  = in_resp && !grant_reg && s.bvalid;
    assign m1.bvalid  = in_resp &&  grant_reg && s.bvalid;
    assign m0.bid     = s.bid;
    assign m1.bid     = s.bid;
    assign m0.bresp   = s.bresp;
    assign m1.bresp   = s.bresp;

    assign grant    = grant_reg;
    assign busy     = (state_reg != IDLE);
    assign prot_err = prot_err_reg;

    // Burst sequencing plus beat-count and ID consistency checks.
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        rr_last_next  = rr_last_reg;
        beat_cnt_next = beat_cnt_reg;
        len_next      = len_reg;
        id_next       = id_reg;
        prot_err_next = prot_err_reg;
        case (state_reg)
            IDLE: begin
                if (m0.awvalid || m1.awvalid) begin
                    grant_next = pick_gnt;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    id_next       = sel_awid;
                    len_next      = sel_awlen;
                    beat_cnt_next = '0;
                    state_next    = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    beat_cnt_next = beat_cnt_reg + 4'd1;
                    if (sel_wid != id_reg) begin
                        prot_err_next = 1'b1;
                    end
                    if (sel_wlast) begin
                        // Short or long burst: wlast not on beat awlen+1.
                        if (beat_cnt_reg != len_reg) begin
                            prot_err_next = 1'b1;
                        end
                        state_next = RESP;
                    end else if (beat_cnt_reg == len_reg) begin
                        // Final expected beat without wlast; keep forwarding.
                        prot_err_next = 1'b1;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    if (s.bid != id_reg) begin
                        prot_err_next = 1'b1;
                    end
                    rr_last_next = grant_reg;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State registers; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            grant_reg    <= 1'b0;
            rr_last_reg  <= 1'b1;
            beat_cnt_reg <= '0;
            len_reg      <= '0;
            id_reg       <= '0;
            prot_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            rr_last_reg  <= rr_last_next;
            beat_cnt_reg <= beat_cnt_next;
            len_reg      <= len_next;
            id_reg       <= id_next;
            prot_err_reg <= prot_err_next;
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: two master drivers, a simple slave
// responder and hand-computed expectations for each scenario.
module tb_axi_wr_arbiter;
    import axi_arb_pkg::*;

    localparam int LIMIT = 300;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_wr_arbiter_if #(.A_WIDTH(16), .D_WIDTH(16)) m0_if ();
    axi_wr_arbiter_if #(.A_WIDTH(16), .D_WIDTH(16)) m1_if ();
    axi_wr_arbiter_if #(.A_WIDTH(16), .D_WIDTH(16)) s_if ();

    logic grant, busy, prot_err;

    axi_wr_arbiter #(.A_WIDTH(16), .D_WIDTH(16)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .grant    (grant),
        .busy     (busy),
        .prot_err (prot_err)
    );

    // Master driver state, indexed by master number.
    logic [8:0]  mi_awid   [2];
    logic [15:0] mi_awaddr [2];
    logic [3:0]  mi_awlen  [2];
    logic        mi_awvalid[2];
    logic [8:0]  mi_wid    [2];
    logic [15:0] mi_wdata  [2];
    logic        mi_wlast  [2];
    logic        mi_wvalid [2];
    logic        mi_bready [2];
    logic        mo_awready[2];
    logic        mo_wready [2];
    logic        mo_bvalid [2];
    logic [8:0]  mo_bid    [2];
    logic [1:0]  mo_bresp  [2];

    assign m0_if.awid = mi_awid[0];     assign m1_if.awid = mi_awid[1];
    assign m0_if.awaddr = mi_awaddr[0]; assign m1_if.awaddr = mi_awaddr[1];
    assign m0_if.awlen = mi_awlen[0];   assign m1_if.awlen = mi_awlen[1];
    assign m0_if.awsize = 3'd1;         assign m1_if.awsize = 3'd1;
    assign m0_if.awburst = 2'b01;       assign m1_if.awburst = 2'b01;
    assign m0_if.awvalid = mi_awvalid[0]; assign m1_if.awvalid = mi_awvalid[1];
    assign m0_if.wid = mi_wid[0];       assign m1_if.wid = mi_wid[1];
    assign m0_if.wdata = mi_wdata[0];   assign m1_if.wdata = mi_wdata[1];
    assign m0_if.wstrb = 2'b11;         assign m1_if.wstrb = 2'b11;
    assign m0_if.wlast = mi_wlast[0];   assign m1_if.wlast = mi_wlast[1];
    assign m0_if.wvalid = mi_wvalid[0]; assign m1_if.wvalid = mi_wvalid[1];
    assign m0_if.bready = mi_bready[0]; assign m1_if.bready = mi_bready[1];
    assign mo_awready[0] = m0_if.awready; assign mo_awready[1] = m1_if.awready;
    assign mo_wready[0] = m0_if.wready;   assign mo_wready[1] = m1_if.wready;
    assign mo_bvalid[0] = m0_if.bvalid;   assign mo_bvalid[1] = m1_if.bvalid;
    assign mo_bid[0] = m0_if.bid;         assign mo_bid[1] = m1_if.bid;
    assign mo_bresp[0] = m0_if.bresp;     assign mo_bresp[1] = m1_if.bresp;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    int aw_start [2];
    int aw_hs_cyc[2];
    int b_hs_cyc [2];

    // One write burst from master m. Entered and left just after a posedge.
    // nbeats may differ from len+1 to inject errors; do_b=0 abandons the
    // burst after the data phase.
    task automatic mwrite(input int m, input int id, input int len, input int nbeats,
                          input int wid_v, input int dbase, input bit do_b,
                          output int bid, output int bresp, output int bgnt);
        bit ok;
        bid = -1; bresp = -1; bgnt = -1;
        mi_awid[m]    = 9'(id);
        mi_awaddr[m]  = 16'h0100;
        mi_awlen[m]   = 4'(len);
        mi_awvalid[m] = 1'b1;
        aw_start[m]   = cyc;
        ok = 1'b0;
        for (int k = 0; k < LIMIT && !ok; k++) begin
            @(negedge clk);
            if (mo_awready[m]) begin ok = 1'b1; aw_hs_cyc[m] = cyc; end
        end
        chk($sformatf("m%0d_aw_handshake", m), int'(ok), 1);
        @(posedge clk); #1;
        mi_awvalid[m] = 1'b0;
        if (!ok) return;
        for (int b = 0; b < nbeats; b++) begin
            mi_wid[m]    = 9'(wid_v);
            mi_wdata[m]  = 16'(dbase + b);
            mi_wlast[m]  = (b == nbeats - 1);
            mi_wvalid[m] = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < LIMIT && !ok; k++) begin
                @(negedge clk);
                if (mo_wready[m]) ok = 1'b1;
            end
            if (!ok) chk($sformatf("m%0d_w_beat%0d_handshake", m, b), 0, 1);
            @(posedge clk); #1;
        end
        mi_wvalid[m] = 1'b0;
        mi_wlast[m]  = 1'b0;
        if (!do_b) begin
            $display("burst m%0d id=%0d abandoned after %0d beats", m, id, nbeats);
            return;
        end
        mi_bready[m] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < LIMIT && !ok; k++) begin
            @(negedge clk);
            if (mo_bvalid[m]) begin
                ok = 1'b1;
                bid = int'(mo_bid[m]);
                bresp = int'(mo_bresp[m]);
                bgnt = int'(grant);
                b_hs_cyc[m] = cyc;
            end
        end
        if (!ok) chk($sformatf("m%0d_b_handshake", m), 0, 1);
        @(posedge clk); #1;
        mi_bready[m] = 1'b0;
        $display("burst m%0d id=%0d len=%0d beats=%0d -> bid=%0d bresp=%0d grant=%0d",
                 m, id, len, nbeats, bid, bresp, bgnt);
    endtask

    // Slave responder and observation state.
    int   wq[$];
    int   gnt_log[$];
    int   aw_rise_cyc = -1;
    int   wlast_cyc = -1;
    int   perr_cyc = -1;
    bit   wr_toggle = 1'b0;
    bit   bid_force_en = 1'b0;
    int   bid_force = 0;
    int   viol = 0;

    initial begin
        bit aw_h, w_h, b_h, b_pend, rst_seen, awv_prev, perr_prev;
        logic [8:0] awid_seen;
        b_pend = 1'b0; awv_prev = 1'b0; perr_prev = 1'b0; awid_seen = '0;
        s_if.awready = 1'b1;
        s_if.wready  = 1'b1;
        s_if.bvalid  = 1'b0;
        s_if.bid     = '0;
        s_if.bresp   = OKAY;
        forever begin
            @(negedge clk);
            rst_seen = !rstn;
            aw_h = s_if.awvalid && s_if.awready;
            w_h  = s_if.wvalid && s_if.wready;
            b_h  = s_if.bvalid && s_if.bready;
            if (s_if.awvalid && !awv_prev) aw_rise_cyc = cyc;
            awv_prev = s_if.awvalid;
            if (prot_err && !perr_prev) perr_cyc = cyc;
            perr_prev = prot_err;
            if (aw_h) begin
                awid_seen = s_if.awid;
                gnt_log.push_back(int'(grant));
            end
            if (w_h) begin
                wq.push_back(int'(s_if.wdata));
                if (s_if.wlast) begin b_pend = 1'b1; wlast_cyc = cyc; end
            end
            if (rst_seen) b_pend = 1'b0;
            @(posedge clk); #1;
            if (b_h || rst_seen) s_if.bvalid = 1'b0;
            if (b_pend) begin
                s_if.bvalid = 1'b1;
                s_if.bid    = bid_force_en ? 9'(bid_force) : awid_seen;
                s_if.bresp  = OKAY;
                b_pend      = 1'b0;
            end
            s_if.wready = wr_toggle ? ~s_if.wready : 1'b1;
        end
    end

    // The master that does not own the bus must never see a ready or a valid.
    always @(negedge clk) begin
        if (busy && !grant && (mo_awready[1] || mo_wready[1] || mo_bvalid[1])) viol++;
        if (busy &&  grant && (mo_awready[0] || mo_wready[0] || mo_bvalid[0])) viol++;
    end

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int bid, bresp, bg;
        int b0, r0, g0, b1, r1, g1;
        for (int i = 0; i < 2; i++) begin
            mi_awid[i] = '0; mi_awaddr[i] = '0; mi_awlen[i] = '0; mi_awvalid[i] = 1'b0;
            mi_wid[i] = '0; mi_wdata[i] = '0; mi_wlast[i] = 1'b0; mi_wvalid[i] = 1'b0;
            mi_bready[i] = 1'b0;
        end

        // Reset state, with a request pending to show reset dominates.
        rstn = 1'b0;
        mi_awvalid[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_prot_err", int'(prot_err), 0);
        chk("rst_s_awvalid", int'(s_if.awvalid), 0);
        chk("rst_s_wvalid", int'(s_if.wvalid), 0);
        chk("rst_s_bready", int'(s_if.bready), 0);
        chk("rst_m0_awready", int'(m0_if.awready), 0);
        chk("rst_m1_wready", int'(m1_if.wready), 0);
        chk("rst_m0_bvalid", int'(m0_if.bvalid), 0);
        mi_awvalid[0] = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single 4-beat write from m0.
        wq.delete(); viol = 0;
        mwrite(0, 5, 3, 4, 5, 'hA000, 1'b1, bid, bresp, bg);
        chk("t1_aw_latency", aw_rise_cyc - aw_start[0], 1);
        chk("t1_beats", wq.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t1_wdata%0d", i), (i < wq.size()) ? wq[i] : -1, 'hA000 + i);
        chk("t1_bid", bid, 5);
        chk("t1_bresp", bresp, 0);
        chk("t1_grant", bg, 0);
        chk("t1_prot_err", int'(prot_err), 0);

        // Simultaneous requests straight out of reset.
        do_reset();
        viol = 0;
        fork
            mwrite(0, 1, 1, 2, 1, 'hC000, 1'b1, b0, r0, g0);
            mwrite(1, 2, 1, 2, 2, 'hD000, 1'b1, b1, r1, g1);
        join
        chk("t2_m0_grant", g0, 0);
        chk("t2_m1_grant", g1, 1);
        chk("t2_m0_bid", b0, 1);
        chk("t2_m1_bid", b1, 2);
        chk("t2_m0_first", int'(aw_hs_cyc[0] < aw_hs_cyc[1]), 1);
        chk("t2_m1_aw_after_b", aw_hs_cyc[1] - b_hs_cyc[0], 2);
        chk("t2_nongrant_quiet", viol, 0);

        // Slave W back-pressure on a 2-beat burst.
        wq.delete();
        wr_toggle = 1'b1;
        mwrite(0, 3, 1, 2, 3, 'hB000, 1'b1, bid, bresp, bg);
        wr_toggle = 1'b0;
        chk("t3_beats", wq.size(), 2);
        chk("t3_wdata0", (wq.size() > 0) ? wq[0] : -1, 'hB000);
        chk("t3_wdata1", (wq.size() > 1) ? wq[1] : -1, 'hB001);
        chk("t3_prot_err", int'(prot_err), 0);

        // len=2 burst ended after 2 beats.
        mwrite(0, 4, 2, 2, 4, 'hE000, 1'b1, bid, bresp, bg);
        chk("t4_perr_timing", perr_cyc - wlast_cyc, 1);
        chk("t4_prot_err", int'(prot_err), 1);
        mwrite(1, 8, 0, 1, 8, 'h1000, 1'b1, bid, bresp, bg);
        chk("t4_clean_bid", bid, 8);
        chk("t4_prot_err_sticky", int'(prot_err), 1);

        // Slave answers with the wrong BID.
        do_reset();
        chk("t5_prot_err_cleared", int'(prot_err), 0);
        bid_force_en = 1'b1; bid_force = 6;
        mwrite(0, 5, 0, 1, 5, 'h2000, 1'b1, bid, bresp, bg);
        bid_force_en = 1'b0;
        chk("t5_bid", bid, 6);
        chk("t5_prot_err", int'(prot_err), 1);

        // Reset in the middle of a data phase.
        do_reset();
        mwrite(0, 5, 3, 2, 5, 'hF000, 1'b0, bid, bresp, bg);
        chk("t6_busy_before", int'(busy), 1);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_busy", int'(busy), 0);
        chk("t6_s_awvalid", int'(s_if.awvalid), 0);
        chk("t6_s_wvalid", int'(s_if.wvalid), 0);
        chk("t6_s_bready", int'(s_if.bready), 0);
        chk("t6_m0_awready", int'(m0_if.awready), 0);
        chk("t6_m0_wready", int'(m0_if.wready), 0);
        chk("t6_m0_bvalid", int'(m0_if.bvalid), 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        wq.delete();
        mwrite(1, 7, 1, 2, 7, 'h7000, 1'b1, bid, bresp, bg);
        chk("t6_m1_grant", bg, 1);
        chk("t6_m1_bid", bid, 7);
        chk("t6_m1_beats", wq.size(), 2);
        chk("t6_prot_err", int'(prot_err), 0);

        // Both masters requesting continuously for six bursts.
        gnt_log.delete(); viol = 0;
        fork
            begin
                int bb, rr, gg;
                for (int i = 0; i < 3; i++) mwrite(0, 10 + i, 0, 1, 10 + i, 'h3000, 1'b1, bb, rr, gg);
            end
            begin
                int bb, rr, gg;
                for (int i = 0; i < 3; i++) mwrite(1, 20 + i, 0, 1, 20 + i, 'h4000, 1'b1, bb, rr, gg);
            end
        join
        chk("t7_bursts", gnt_log.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t7_grant%0d", i), (i < gnt_log.size()) ? gnt_log[i] : -1, i % 2);
        chk("t7_nongrant_quiet", viol, 0);
        chk("t7_prot_err", int'(prot_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, compared=%0d mismatched=%0d", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
